// File: rtl/io_pkg.sv
// io_pkg: register map, debounce default and 7-segment glyphs shared by the I/O responder.
package io_pkg;
  localparam logic [31:0] ADDR_HEX = 32'hF000_0000;
  localparam logic [31:0] ADDR_LEDR = 32'hF000_0004;
  localparam logic [31:0] ADDR_LEDG = 32'hF000_0008;
  localparam logic [31:0] ADDR_KEY = 32'hF000_0010;
  localparam logic [31:0] ADDR_SW = 32'hF000_0014;
  localparam logic [31:0] ADDR_KEYEDGE = 32'hF000_0018;
  localparam int unsigned DEBOUNCE_DEFAULT = 500000;
  // Active-low segments, bit order g..a, digits 0-F.
  localparam logic [6:0] SEG7 [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/seven_seg_decoder.sv
// seven_seg_decoder: one hex nibble to active-low 7-segment pattern.
module seven_seg_decoder
  import io_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG7[nib_i];
endmodule

// File: rtl/io_responder.sv
// io_responder: memory-mapped KEY/SW/LEDR/LEDG/HEX responder with synchronised,
// debounced inputs and a sticky write-1-to-clear key-press register.
module io_responder
  import io_pkg::*;
#(
  parameter int unsigned DBITS = 32,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_BITS = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic             wrEn,
  input  logic [DBITS-1:0] wrData,
  output logic [DBITS-1:0] rdData,
  output logic             sel,
  input  logic [9:0]       SW,
  input  logic [3:0]       KEY,
  output logic [9:0]       LEDR,
  output logic [7:0]       LEDG,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3
);
  localparam logic [CNT_BITS-1:0] DB_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  // Bits [3:0] are keys (inverted so 1 = pressed), bits [13:4] are switches.
  logic [13:0] raw, s1_q, s2_q, stable_q, stable_d;
  logic [13:0][CNT_BITS-1:0] cnt_q, cnt_d;
  logic [15:0] hex_q, hex_d;
  logic [9:0] ledr_q, ledr_d;
  logic [7:0] ledg_q, ledg_d;
  logic [3:0] kedge_q, kedge_d;
  logic hit_hex, hit_ledr, hit_ledg, hit_key, hit_sw, hit_edge;
  logic unused_wr_hi;

  assign raw = {SW, ~KEY};

  genvar i;
  generate
    for (i = 0; i < 14; i++) begin : g_db
      assign cnt_d[i] = (s2_q[i] == stable_q[i] || cnt_q[i] == DB_LAST) ? '0 : cnt_q[i] + 1'b1;
      assign stable_d[i] = (s2_q[i] != stable_q[i] && cnt_q[i] == DB_LAST) ? s2_q[i] : stable_q[i];
    end
  endgenerate

  assign hit_hex = addr == DBITS'(ADDR_HEX);
  assign hit_ledr = addr == DBITS'(ADDR_LEDR);
  assign hit_ledg = addr == DBITS'(ADDR_LEDG);
  assign hit_key = addr == DBITS'(ADDR_KEY);
  assign hit_sw = addr == DBITS'(ADDR_SW);
  assign hit_edge = addr == DBITS'(ADDR_KEYEDGE);
  assign sel = |{hit_hex, hit_ledr, hit_ledg, hit_key, hit_sw, hit_edge};
  assign unused_wr_hi = ^wrData[DBITS-1:16];

  always_comb begin
    hex_d = (wrEn && hit_hex) ? wrData[15:0] : hex_q;
    ledr_d = (wrEn && hit_ledr) ? wrData[9:0] : ledr_q;
    ledg_d = (wrEn && hit_ledg) ? wrData[7:0] : ledg_q;
    // A press landing in the same cycle as a clear survives.
    kedge_d = (kedge_q & ~((wrEn && hit_edge) ? wrData[3:0] : 4'h0)) | (stable_d[3:0] & ~stable_q[3:0]);
    rdData = hit_hex  ? DBITS'(hex_q) :
             hit_ledr ? DBITS'(ledr_q) :
             hit_ledg ? DBITS'(ledg_q) :
             hit_key  ? DBITS'(stable_q[3:0]) :
             hit_sw   ? DBITS'(stable_q[13:4]) :
             hit_edge ? DBITS'(kedge_q) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= '0;
      s2_q <= '0;
      stable_q <= '0;
      cnt_q <= '0;
      hex_q <= '0;
      ledr_q <= '0;
      ledg_q <= '0;
      kedge_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      stable_q <= stable_d;
      cnt_q <= cnt_d;
      hex_q <= hex_d;
      ledr_q <= ledr_d;
      ledg_q <= ledg_d;
      kedge_q <= kedge_d;
    end
  end

  assign LEDR = ledr_q;
  assign LEDG = ledg_q;

  seven_seg_decoder u_hex0 (.nib_i(hex_q[3:0]), .seg_o(HEX0));
  seven_seg_decoder u_hex1 (.nib_i(hex_q[7:4]), .seg_o(HEX1));
  seven_seg_decoder u_hex2 (.nib_i(hex_q[11:8]), .seg_o(HEX2));
  seven_seg_decoder u_hex3 (.nib_i(hex_q[15:12]), .seg_o(HEX3));
endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: directed stimulus with a queued scoreboard checked at the falling edge.
module tb_io_responder;
  localparam logic [31:0] A_HEX = 32'hF000_0000;
  localparam logic [31:0] A_LEDR = 32'hF000_0004;
  localparam logic [31:0] A_LEDG = 32'hF000_0008;
  localparam logic [31:0] A_KEY = 32'hF000_0010;
  localparam logic [31:0] A_SW = 32'hF000_0014;
  localparam logic [31:0] A_EDGE = 32'hF000_0018;
  localparam logic [31:0] HEX_ZERO = {4'h0, 7'h40, 7'h40, 7'h40, 7'h40};

  logic clk = 0, reset = 0, wrEn = 0, sel;
  logic [31:0] addr = 0, wrData = 0, rdData;
  logic [9:0] SW = 0, LEDR;
  logic [3:0] KEY = 4'hF;
  logic [7:0] LEDG;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;

  io_responder #(.DBITS(32), .DEBOUNCE_CYCLES(4), .CNT_BITS(20)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wrEn(wrEn), .wrData(wrData),
    .rdData(rdData), .sel(sel), .SW(SW), .KEY(KEY), .LEDR(LEDR), .LEDG(LEDG),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  always #5 clk = ~clk;

  typedef enum int {K_RD, K_SEL, K_LEDR, K_LEDG, K_HEX} kind_t;
  typedef struct {
    kind_t k;
    logic [31:0] exp;
    string name;
  } item_t;

  item_t q[$];
  int tests = 0, fails = 0;

  function automatic logic [31:0] actual(kind_t k);
    case (k)
      K_RD: return rdData;
      K_SEL: return {31'b0, sel};
      K_LEDR: return {22'b0, LEDR};
      K_LEDG: return {24'b0, LEDG};
      default: return {4'h0, HEX3, HEX2, HEX1, HEX0};
    endcase
  endfunction

  initial forever begin
    @(negedge clk);
    while (q.size() > 0) begin
      item_t it;
      logic [31:0] a;
      it = q.pop_front();
      a = actual(it.k);
      tests++;
      if (a !== it.exp) begin
        fails++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", it.name, a, it.exp);
      end
    end
  end

  task automatic expect_(input kind_t k, input logic [31:0] e, input string n);
    item_t it;
    it.k = k;
    it.exp = e;
    it.name = n;
    q.push_back(it);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wrData = d;
    wrEn = 1;
    step(1);
    wrEn = 0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] e, input string n);
    addr = a;
    expect_(K_RD, e, n);
    step(1);
  endtask

  initial begin
    step(2);
    expect_(K_LEDR, 0, "reset_ledr");
    expect_(K_LEDG, 0, "reset_ledg");
    expect_(K_HEX, HEX_ZERO, "reset_hex");
    load(A_KEY, 0, "reset_key");
    reset = 1;
    step(1);
    store(A_HEX, 32'h0000_1234);
    expect_(K_HEX, {4'h0, 7'h79, 7'h24, 7'h30, 7'h19}, "hex_1234_pins");
    load(A_HEX, 32'h1234, "hex_1234_read");
    store(A_HEX, 32'hDEAD_89EF);
    expect_(K_HEX, {4'h0, 7'h00, 7'h10, 7'h06, 7'h0E}, "hex_89ef_pins");
    load(A_HEX, 32'h89EF, "hex_89ef_read");
    store(A_LEDR, 32'h0000_03FF);
    expect_(K_LEDR, 32'h3FF, "ledr_pins");
    store(A_LEDG, 32'h0000_FFA5);
    expect_(K_LEDG, 32'hA5, "ledg_pins");
    expect_(K_LEDR, 32'h3FF, "ledr_hold");
    load(A_LEDR, 32'h3FF, "ledr_read");
    load(A_LEDG, 32'hA5, "ledg_read");
    addr = 32'hF000_001C;
    wrData = 0;
    wrEn = 1;
    expect_(K_SEL, 0, "unmapped_sel");
    expect_(K_RD, 0, "unmapped_rd");
    step(1);
    addr = 32'hF000_0005;
    expect_(K_SEL, 0, "misaligned_sel");
    step(1);
    wrEn = 0;
    expect_(K_LEDR, 32'h3FF, "unmapped_ledr");
    expect_(K_LEDG, 32'hA5, "unmapped_ledg");
    expect_(K_HEX, {4'h0, 7'h00, 7'h10, 7'h06, 7'h0E}, "unmapped_hex");
    store(A_KEY, 32'hF);
    load(A_KEY, 0, "key_store_ignored");
    load(A_SW, 0, "sw_idle");
    KEY = 4'b1011;
    step(2);
    KEY = 4'hF;
    step(1);
    KEY = 4'b1011;
    step(5);
    load(A_KEY, 0, "key_not_yet");
    load(A_KEY, 4, "key_stable");
    load(A_EDGE, 4, "edge_set");
    KEY = 4'hF;
    step(8);
    load(A_KEY, 0, "key_released");
    KEY = 4'b1011;
    step(8);
    load(A_EDGE, 4, "edge_sticky");
    store(A_EDGE, 32'h4);
    load(A_EDGE, 0, "edge_cleared");
    KEY = 4'hF;
    step(8);
    load(A_EDGE, 0, "edge_no_release_set");
    KEY = 4'b1011;
    step(5);
    store(A_EDGE, 32'h4);
    load(A_EDGE, 4, "edge_set_wins");
    store(A_EDGE, 32'h4);
    load(A_EDGE, 0, "edge_clear_later");
    SW = 10'h2AA;
    step(5);
    load(A_SW, 0, "sw_not_yet");
    load(A_SW, 32'h2AA, "sw_stable");
    load(A_KEY, 4, "key_only_keys");
    SW = 10'h000;
    step(3);
    SW = 10'h2AA;
    step(10);
    load(A_SW, 32'h2AA, "sw_glitch_ignored");
    addr = A_KEY;
    reset = 0;
    expect_(K_LEDR, 0, "midrst_ledr");
    expect_(K_LEDG, 0, "midrst_ledg");
    expect_(K_HEX, HEX_ZERO, "midrst_hex");
    expect_(K_RD, 0, "midrst_key");
    step(1);
    reset = 1;
    step(1);
    expect_(K_LEDR, 0, "post_rst_ledr");
    load(A_EDGE, 0, "post_rst_edge");
    step(2);
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
